// File: rtl/wfg_drive_spi_mc_if.sv
// Waveform AXI-Stream word channel feeding the multi-chip-select SPI drive core.
// tuser carries the target chip-select index for each word.
interface wfg_drive_spi_mc_if #(
    parameter int DATA_W = 32,
    parameter int CSW    = 2
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [CSW-1:0]    tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/wfg_drive_spi_mc.sv
// Multi-chip-select SPI drive: one stream word per pattern-sync pulse, shifted out on the CS chosen by tuser.
// Optional MISO capture path is built when WFG_DRIVE_SPI_MISO_EN is defined.
module wfg_drive_spi_mc #(
    parameter int  DATA_W = 32,
    parameter int  NCS    = 4,
    parameter int  DIV_W  = 8,
    parameter int  CSW    = (NCS > 1) ? $clog2(NCS) : 1,
    localparam int LEN_W  = $clog2(DATA_W)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wfg_pat_sync_i,
    wfg_drive_spi_mc_if.slave  wfg_axis,
    input  logic               ctrl_en_q_i,
    input  logic [DIV_W-1:0]   clkcfg_div_q_i,
    input  logic [LEN_W-1:0]   cfg_len_q_i,
    input  logic               cfg_cpol_q_i,
    input  logic               cfg_cpha_q_i,
    input  logic               cfg_lsbfirst_q_i,
    input  logic               cfg_sspol_q_i,
    output logic               busy_o,
    output logic               drop_o,
    output logic               wfg_drive_spi_sclk_o,
    output logic [NCS-1:0]     wfg_drive_spi_cs_no,
`ifdef WFG_DRIVE_SPI_MISO_EN
    input  logic               wfg_drive_spi_sdi_i,
    output logic [DATA_W-1:0]  rx_data_o,
    output logic               rx_valid_o,
`endif
    output logic               wfg_drive_spi_sdo_o
);

    localparam int EDGE_W = LEN_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  hp_q, hp_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CSW-1:0]    cs_idx_q, cs_idx_d;
    logic              sclk_q, sclk_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              sspol_q, sspol_d;
`ifdef WFG_DRIVE_SPI_MISO_EN
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
`endif

    logic              idle;
    logic              tick;
    logic              ready;
    logic              oob;
    logic              last_edge;
    logic              sample_edge;
    logic [EDGE_W-1:0] edge_nxt;
    logic [EDGE_W-1:0] edge_total;
    logic [LEN_W-1:0]  bit_pos;

    assign idle        = (state_q == ST_IDLE);
    assign tick        = (hp_q == div_q);
    assign ready       = idle & ctrl_en_q_i & wfg_axis.tvalid & wfg_pat_sync_i;
    assign oob         = (int'(wfg_axis.tuser) >= NCS);
    assign edge_nxt    = edge_q + EDGE_W'(1);
    assign edge_total  = (EDGE_W'(len_q) + EDGE_W'(1)) << 1;
    assign last_edge   = (edge_nxt == edge_total);
    // Odd edges are leading; with CPHA=0 data is sampled on them, with CPHA=1 on trailing ones.
    assign sample_edge = edge_nxt[0] ^ cpha_q;
    assign bit_pos     = lsb_q ? idx_q : (len_q - idx_q);

    // NOTE: every _d gets its hold value first so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        div_d      = div_q;
        edge_d     = edge_q;
        idx_d      = idx_q;
        len_d      = len_q;
        data_d     = data_q;
        cs_idx_d   = cs_idx_q;
        sclk_d     = sclk_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sspol_d    = sspol_q;
        drop_o     = 1'b0;
`ifdef WFG_DRIVE_SPI_MISO_EN
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    if (oob) begin
                        drop_o = 1'b1;
                    end else begin
                        state_d  = ST_CS_SETUP;
                        hp_d     = '0;
                        edge_d   = '0;
                        idx_d    = '0;
                        div_d    = clkcfg_div_q_i;
                        len_d    = cfg_len_q_i;
                        data_d   = wfg_axis.tdata;
                        cs_idx_d = wfg_axis.tuser;
                        sclk_d   = cfg_cpol_q_i;
                        cpha_d   = cfg_cpha_q_i;
                        lsb_d    = cfg_lsbfirst_q_i;
                        sspol_d  = cfg_sspol_q_i;
`ifdef WFG_DRIVE_SPI_MISO_EN
                        rx_sh_d  = '0;
`endif
                    end
                end
            end

            ST_CS_SETUP: begin
                hp_d = tick ? '0 : hp_q + DIV_W'(1);
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                hp_d = tick ? '0 : hp_q + DIV_W'(1);
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
`ifdef WFG_DRIVE_SPI_MISO_EN
                    if (sample_edge) begin
                        rx_sh_d[bit_pos] = wfg_drive_spi_sdi_i;
                    end
`endif
                    // CPHA=0 holds the last bit through the final edge; CPHA=1 presents bit 0 on edge 1.
                    if (!sample_edge && !(cpha_q ? (edge_nxt == EDGE_W'(1)) : last_edge)) begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                    if (last_edge) begin
                        state_d = ST_CS_HOLD;
                    end
                end
            end

            ST_CS_HOLD: begin
                hp_d = tick ? '0 : hp_q + DIV_W'(1);
                if (tick) begin
                    state_d    = ST_IDLE;
`ifdef WFG_DRIVE_SPI_MISO_EN
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
`endif
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            hp_q       <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            cs_idx_q   <= '0;
            sclk_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sspol_q    <= 1'b0;
`ifdef WFG_DRIVE_SPI_MISO_EN
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cs_idx_q   <= cs_idx_d;
            sclk_q     <= sclk_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sspol_q    <= sspol_d;
`ifdef WFG_DRIVE_SPI_MISO_EN
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`endif
        end
    end

    // Idle levels follow the live cpol/sspol so reset and idle outputs track the register block.
    assign wfg_axis.tready      = ready;
    assign busy_o               = ~idle;
    assign wfg_drive_spi_sclk_o = idle ? cfg_cpol_q_i : sclk_q;
    assign wfg_drive_spi_sdo_o  = idle ? 1'b0 : data_q[bit_pos];

    always_comb begin
        for (int i = 0; i < NCS; i++) begin
            if (idle) begin
                wfg_drive_spi_cs_no[i] = ~cfg_sspol_q_i;
            end else if (int'(cs_idx_q) == i) begin
                wfg_drive_spi_cs_no[i] = sspol_q;
            end else begin
                wfg_drive_spi_cs_no[i] = ~sspol_q;
            end
        end
    end

`ifdef WFG_DRIVE_SPI_MISO_EN
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`endif

endmodule
